// File: rtl/alu_decode_stage.sv
// RV32I decode stage: registers the ALU op, operand selects, immediate
// and control flags for execute, and counts illegal instructions.
module alu_decode_stage #(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_op,
    output logic [1:0]           src1_sel,
    output logic                 src2_sel,
    output logic [31:0]          imm,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    output logic [4:0]           rd_addr,
    output logic                 rd_we,
    output logic                 is_branch,
    output logic                 is_jump,
    output logic                 is_load,
    output logic                 is_store,
    output logic                 illegal,
    output logic [31:0]          out_pc,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_EQL  = 4'd10;
    localparam logic [3:0] ALU_NEQ  = 4'd11;
    localparam logic [3:0] ALU_GTE  = 4'd12;
    localparam logic [3:0] ALU_GTEU = 4'd13;
    localparam logic [3:0] ALU_NOP  = 4'd14;
    localparam logic [3:0] ALU_ERR  = 4'd15;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  s1;
        logic        s2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic        jp;
        logic        ld;
        logic        st;
        logic        ill;
        logic [31:0] pc;
    } dec_t;

    function automatic logic [3:0] f3_op(input logic [2:0] f3);
        logic [3:0] r;
        case (f3)
            3'b000:  r = ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        ok;
    logic        accept;
    dec_t        d;
    dec_t        q;
    logic        vld;
    logic [ILL_CNT_W-1:0] cnt;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        d     = '0;
        ok    = 1'b0;
        d.op  = ALU_ADD;
        d.rs1 = in_instr[19:15];
        d.rs2 = in_instr[24:20];
        d.rd  = in_instr[11:7];
        d.pc  = in_pc;
        case (opc)
            OPC_LUI: begin
                ok = 1'b1; d.s1 = 2'd2; d.s2 = 1'b1;
                d.imm = imm_u; d.we = 1'b1;
            end
            OPC_AUIPC: begin
                ok = 1'b1; d.s1 = 2'd1; d.s2 = 1'b1;
                d.imm = imm_u; d.we = 1'b1;
            end
            OPC_JAL: begin
                ok = 1'b1; d.s1 = 2'd1; d.s2 = 1'b1;
                d.imm = imm_j; d.we = 1'b1; d.jp = 1'b1;
            end
            OPC_JALR: begin
                ok = (f3 == 3'b000); d.s2 = 1'b1;
                d.imm = imm_i; d.we = 1'b1; d.jp = 1'b1;
            end
            OPC_BRANCH: begin
                ok = 1'b1; d.imm = imm_b; d.br = 1'b1;
                case (f3)
                    3'b000:  d.op = ALU_EQL;
                    3'b001:  d.op = ALU_NEQ;
                    3'b100:  d.op = ALU_SLT;
                    3'b101:  d.op = ALU_GTE;
                    3'b110:  d.op = ALU_SLTU;
                    3'b111:  d.op = ALU_GTEU;
                    default: ok = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                d.s2 = 1'b1; d.imm = imm_i; d.we = 1'b1; d.ld = 1'b1;
            end
            OPC_STORE: begin
                ok = !f3[2] && (f3 != 3'b011);
                d.s2 = 1'b1; d.imm = imm_s; d.st = 1'b1;
            end
            OPC_OPIMM: begin
                ok = 1'b1; d.s2 = 1'b1; d.imm = imm_i; d.we = 1'b1;
                d.op = f3_op(f3);
                // shifts carry a zero-extended shamt and a constrained funct7
                if (f3 == 3'b001) begin
                    d.imm = {27'b0, in_instr[24:20]};
                    ok = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    d.imm = {27'b0, in_instr[24:20]};
                    ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    if (f7[5]) d.op = ALU_SRA;
                end
            end
            OPC_OP: begin
                d.we = 1'b1;
                if (f7 == 7'b0000000) begin
                    ok = 1'b1; d.op = f3_op(f3);
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000) begin
                        ok = 1'b1; d.op = ALU_SUB;
                    end else if (f3 == 3'b101) begin
                        ok = 1'b1; d.op = ALU_SRA;
                    end
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d.op  = ALU_ERR;
            d.ill = 1'b1;
            d.we  = 1'b0;
            d.br  = 1'b0;
            d.jp  = 1'b0;
            d.ld  = 1'b0;
            d.st  = 1'b0;
        end else if (d.rd == 5'd0) begin
            d.we = 1'b0;
        end
    end

    assign in_ready = !vld || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            q    <= '0;
            q.op <= ALU_NOP;
            cnt  <= '0;
        end else if (flush) begin
            vld  <= 1'b0;
            q.op <= ALU_NOP;
        end else if (accept) begin
            vld <= 1'b1;
            q   <= d;
            if (d.ill && (cnt != '1)) cnt <= cnt + 1'b1;
        end else if (out_ready) begin
            vld  <= 1'b0;
            q.op <= ALU_NOP;
        end
    end

    assign out_valid = vld;
    assign alu_op    = q.op;
    assign src1_sel  = q.s1;
    assign src2_sel  = q.s2;
    assign imm       = q.imm;
    assign rs1_addr  = q.rs1;
    assign rs2_addr  = q.rs2;
    assign rd_addr   = q.rd;
    assign rd_we     = q.we;
    assign is_branch = q.br;
    assign is_jump   = q.jp;
    assign is_load   = q.ld;
    assign is_store  = q.st;
    assign illegal   = q.ill;
    assign out_pc    = q.pc;
    assign ill_count = cnt;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vectors, backpressure,
// flush and illegal-count saturation.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, imm, out_pc;
    logic [3:0]  alu_op;
    logic [1:0]  src1_sel;
    logic        src2_sel, rd_we, is_branch, is_jump, is_load, is_store;
    logic        illegal;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [7:0]  ill_count;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    alu_decode_stage #(.ILL_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .src1_sel(src1_sel), .src2_sel(src2_sel),
        .imm(imm), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .rd_we(rd_we), .is_branch(is_branch),
        .is_jump(is_jump), .is_load(is_load), .is_store(is_store),
        .illegal(illegal), .out_pc(out_pc), .ill_count(ill_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_op", {28'b0, alu_op}, 14);
        chk("rst_ready", {31'b0, in_ready}, 1);
        chk("rst_cnt", {24'b0, ill_count}, 0);
        chk("rst_imm", imm, 0);

        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
        step();
        chk("addi_valid", {31'b0, out_valid}, 1);
        chk("addi_op", {28'b0, alu_op}, 0);
        chk("addi_s2", {31'b0, src2_sel}, 1);
        chk("addi_imm", imm, 5);
        chk("addi_rd", {27'b0, rd_addr}, 1);
        chk("addi_we", {31'b0, rd_we}, 1);
        chk("addi_ill", {31'b0, illegal}, 0);
        chk("addi_pc", out_pc, 32'h100);

        in_instr = 32'h40208133; in_pc = 32'h104;
        step();
        chk("sub_op", {28'b0, alu_op}, 1);
        chk("sub_s2", {31'b0, src2_sel}, 0);
        chk("sub_rs1", {27'b0, rs1_addr}, 1);
        chk("sub_rs2", {27'b0, rs2_addr}, 2);

        in_instr = 32'h4010D093;
        step();
        chk("srai_op", {28'b0, alu_op}, 7);
        chk("srai_imm", imm, 1);

        in_instr = 32'h00000063;
        step();
        chk("beq_op", {28'b0, alu_op}, 10);
        chk("beq_br", {31'b0, is_branch}, 1);
        chk("beq_we", {31'b0, rd_we}, 0);

        in_instr = 32'hFFFFFFFF;
        step();
        chk("ill_op", {28'b0, alu_op}, 15);
        chk("ill_flag", {31'b0, illegal}, 1);
        chk("ill_valid", {31'b0, out_valid}, 1);
        chk("ill_cnt", {24'b0, ill_count}, 1);

        in_instr = 32'h123452B7;
        step();
        chk("lui_s1", {30'b0, src1_sel}, 2);
        chk("lui_imm", imm, 32'h12345000);
        chk("lui_ill", {31'b0, illegal}, 0);

        in_instr = 32'h00001017;
        step();
        chk("auipc_s1", {30'b0, src1_sel}, 1);
        chk("auipc_imm", imm, 32'h1000);
        chk("auipc_x0_we", {31'b0, rd_we}, 0);

        in_instr = 32'hFFDFF0EF;
        step();
        chk("jal_imm", imm, 32'hFFFFFFFC);
        chk("jal_jump", {31'b0, is_jump}, 1);
        chk("jal_we", {31'b0, rd_we}, 1);

        in_instr = 32'hFE20AC23;
        step();
        chk("sw_imm", imm, 32'hFFFFFFF8);
        chk("sw_st", {31'b0, is_store}, 1);
        chk("sw_we", {31'b0, rd_we}, 0);

        in_instr = 32'h02009093;
        step();
        chk("slli_f7_op", {28'b0, alu_op}, 15);
        chk("slli_f7_cnt", {24'b0, ill_count}, 2);

        in_valid = 1'b0;
        step();
        chk("drain_valid", {31'b0, out_valid}, 0);
        chk("drain_op", {28'b0, alu_op}, 14);

        in_valid = 1'b1; in_instr = 32'h00500093;
        step();
        out_ready = 1'b0; in_instr = 32'h40208133;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", {31'b0, out_valid}, 1);
            chk("bp_op", {28'b0, alu_op}, 0);
            chk("bp_imm", imm, 5);
            chk("bp_ready", {31'b0, in_ready}, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("rel_ready", {31'b0, in_ready}, 1);
        step();
        chk("rel_op", {28'b0, alu_op}, 1);
        chk("rel_valid", {31'b0, out_valid}, 1);

        flush = 1'b1; in_instr = 32'hFFFFFFFF;
        #1;
        chk("fl_ready", {31'b0, in_ready}, 1);
        step();
        chk("fl_valid", {31'b0, out_valid}, 0);
        chk("fl_op", {28'b0, alu_op}, 14);
        chk("fl_cnt", {24'b0, ill_count}, 2);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("fl_after", {31'b0, out_valid}, 0);

        in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
        for (int i = 0; i < 260; i++) step();
        chk("sat_cnt", {24'b0, ill_count}, 255);
        in_valid = 1'b0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_cnt", {24'b0, ill_count}, 0);
        chk("rst2_valid", {31'b0, out_valid}, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Registered instruction-decode stage that produces the 4-bit ALU operation code plus operand-select, immediate and control fields for the execute stage's ALU.
- Sits between fetch and execute; accepts one RV32I instruction word per valid/ready handshake and presents one decoded bundle per handshake downstream.
- Also counts illegal instructions for debug.

Parameters:
- ILL_CNT_W, 8, width of saturating illegal-instruction counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard held and incoming instruction
- in_valid  input  1  fetch presents instruction
- in_ready  output  1  stage can accept
- in_instr  input  32  instruction word
- in_pc  input  32  instruction address
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts bundle
- alu_op  output  4  ADD0 SUB1 XOR2 OR3 AND4 SLL5 SRL6 SRA7 SLT8 SLTU9 EQL10 NEQ11 GTE12 GTEU13 NOP14 ERR15
- src1_sel  output  2  0=rs1, 1=pc, 2=zero
- src2_sel  output  1  0=rs2, 1=imm
- imm  output  32  sign-extended immediate
- rs1_addr, rs2_addr, rd_addr  output  5 each  register fields
- rd_we  output  1  register writeback enable
- is_branch, is_jump, is_load, is_store  output  1 each  class flags
- illegal  output  1  instruction illegal
- out_pc  output  32  registered in_pc
- ill_count  output  ILL_CNT_W  saturating illegal count

Behaviour:
- Reset, synchronous on rst=1:
  - out_valid=0, alu_op=NOP(14), ill_count=0.
  - All other outputs 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready; decoded bundle is registered with 1-cycle latency (out_valid=1 the next cycle).
  - Bundle held stable while out_valid && !out_ready.
  - If out_valid && out_ready && no accept, out_valid falls to 0; alu_op returns to NOP.
- Flush (priority below rst, above everything else):
  - Next cycle out_valid=0 and alu_op=NOP.
  - An instruction presented in the same cycle is dropped: not decoded, not counted.
  - in_ready is unaffected by flush.
- Decode by opcode[6:0]:
  - LUI 0110111: src1=zero, src2=imm, ADD, U-imm.
  - AUIPC 0010111: src1=pc, src2=imm, ADD, U-imm.
  - JAL 1101111: src1=pc, src2=imm, ADD, J-imm, is_jump.
  - JALR 1100111 (funct3 000 only): src1=rs1, src2=imm, ADD, I-imm, is_jump.
  - BRANCH 1100011: src1=rs1, src2=rs2, B-imm, is_branch, rd_we=0. funct3 000 EQL, 001 NEQ, 100 SLT, 101 GTE, 110 SLTU, 111 GTEU; 010/011 illegal.
  - LOAD 0000011: rs1+I-imm, ADD, is_load. funct3 000,001,010,100,101 legal; others illegal.
  - STORE 0100011: rs1+S-imm, ADD, is_store, rd_we=0. funct3 000..010 legal; others illegal.
  - OP-IMM 0010011: src2=imm, I-imm. funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL/SRA.
    - Shifts: imm = zero-extended shamt (instr[24:20]).
    - SLLI requires funct7=0000000; SRLI requires 0000000; SRAI requires 0100000. Anything else is illegal.
  - OP 0110011: src2=rs2.
    - funct7=0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND by funct3.
    - funct7=0100000: only funct3 000 (SUB) and 101 (SRA) legal.
    - Any other funct7 is illegal.
  - Any other opcode is illegal.
- Illegal instruction:
  - alu_op=ERR(15), illegal=1, rd_we=0, all class flags 0; out_valid still asserted.
  - ill_count +1 on accept, saturating at all-ones.
- rd_we:
  - 1 for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP.
  - Forced 0 when rd_addr=0.
- Register address fields are passed raw from instruction bits regardless of format.

Test Plan:
- Reset then idle -> out_valid=0, alu_op=14, in_ready=1, ill_count=0.
- in_instr=0x00500093 (addi x1,x0,5) -> next cycle alu_op=0, src2_sel=1, imm=5, rd_addr=1, rd_we=1, illegal=0.
- 0x40208133 (sub x2,x1,x2) -> alu_op=1, src2_sel=0; 0x4010D093 (srai x1,x1,1) -> alu_op=7, imm=1.
- 0x00000063 (beq x0,x0,0) -> alu_op=10, is_branch=1, rd_we=0; then 0xFFFFFFFF -> alu_op=15, illegal=1, ill_count=1.
- Backpressure:
  - Stimulus: accept addi, hold out_ready=0 for 3 cycles with in_valid=1.
  - Required: bundle stable, in_ready=0 throughout.
  - On release: next instruction is accepted the same cycle the held one drains.
- Flush:
  - Stimulus: assert flush while holding a bundle and presenting 0xFFFFFFFF.
  - Required: out_valid=0 and alu_op=14 next cycle; ill_count unchanged.
